// File: rtl/branch_resolve_unit_if.sv
// Branch-resolution bus: decode-side request plus registered result/flush outputs.
// BRANCH_STATS_EN adds the BR_CNT/TAKEN_CNT statistics signals.
interface branch_resolve_unit_if #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
);
   logic              IN_VALID;
   logic [2:0]        OP_TF;
   logic [2:0]        COND;
   logic [ADDR_W-1:0] PC;
   logic [ADDR_W-1:0] IMM_TARGET;
   logic [ADDR_W-1:0] REG_TARGET;
   logic              FLAG_WE;
   logic              O, S, C, Z;
   logic              BR_VALID;
   logic              TAKEN;
   logic [ADDR_W-1:0] TARGET;
   logic              LINK_WE;
   logic [ADDR_W-1:0] LINK_VAL;
   logic              FLUSH;
   logic [3:0]        FLAGS_Q;
`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0]  BR_CNT;
   logic [CNT_W-1:0]  TAKEN_CNT;
`endif

   modport master (
      output IN_VALID, OP_TF, COND, PC, IMM_TARGET, REG_TARGET, FLAG_WE, O, S, C, Z,
      input  BR_VALID, TAKEN, TARGET, LINK_WE, LINK_VAL, FLUSH, FLAGS_Q
`ifdef BRANCH_STATS_EN
      , input BR_CNT, TAKEN_CNT
`endif
   );

   modport slave (
      input  IN_VALID, OP_TF, COND, PC, IMM_TARGET, REG_TARGET, FLAG_WE, O, S, C, Z,
      output BR_VALID, TAKEN, TARGET, LINK_WE, LINK_VAL, FLUSH, FLAGS_Q
`ifdef BRANCH_STATS_EN
      , output BR_CNT, TAKEN_CNT
`endif
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution: flag register, condition/target evaluation, flush window.
// Define BRANCH_STATS_EN to add saturating branch/taken statistics counters.
module branch_resolve_unit #(
   parameter int ADDR_W    = 16,
   parameter int FLUSH_CYC = 2,
   parameter int CNT_W     = 16
) (
   input logic                   CLK,
   input logic                   RESET,
   branch_resolve_unit_if.slave  bus
);
   typedef enum logic {S_IDLE, S_FLUSHING} state_t;

   state_t            r_state;
   logic [2:0]        r_fc;
   logic [3:0]        r_flags;
   logic              r_br_valid;
   logic              r_taken;
   logic [ADDR_W-1:0] r_target;
   logic              r_link_we;
   logic [ADDR_W-1:0] r_link_val;

   logic [3:0]        w_flags;
   logic              w_c;
   logic              w_taken;
   logic              w_accept;
   logic              w_is_jal;
   logic [ADDR_W-1:0] w_pc1;
   logic [ADDR_W-1:0] w_target;

   // Same-cycle ALU flag writes bypass the flag register.
   assign w_flags  = bus.FLAG_WE ? {bus.O, bus.S, bus.C, bus.Z} : r_flags;
   assign w_accept = bus.IN_VALID && (r_state != S_FLUSHING);
   assign w_is_jal = (bus.OP_TF == 3'b011);
   assign w_pc1    = bus.PC + ADDR_W'(1);

   always_comb begin
      w_c = 1'b0;
      case (bus.COND)
         3'b000:  w_c = 1'b1;
         3'b001:  w_c = w_flags[2];
         3'b010:  w_c = w_flags[0];
         3'b100:  w_c = w_flags[1];
         3'b101:  w_c = w_flags[2] & w_flags[0];
         3'b111:  w_c = w_flags[3];
         default: w_c = 1'b0;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (bus.OP_TF)
         3'b000:                 w_taken = !w_c;
         3'b001:                 w_taken = w_c;
         3'b010, 3'b011, 3'b100: w_taken = 1'b1;
         default:                w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_target = w_pc1;
      if (w_taken) w_target = (bus.OP_TF == 3'b100) ? bus.REG_TARGET : bus.IMM_TARGET;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_fc       <= 3'd0;
         r_flags    <= 4'd0;
         r_br_valid <= 1'b0;
         r_taken    <= 1'b0;
         r_target   <= '0;
         r_link_we  <= 1'b0;
         r_link_val <= '0;
      end else begin
         if (bus.FLAG_WE) r_flags <= {bus.O, bus.S, bus.C, bus.Z};
         r_br_valid <= w_accept;
         r_link_we  <= w_accept && w_is_jal;
         if (w_accept) begin
            r_taken  <= w_taken;
            r_target <= w_target;
            if (w_is_jal) r_link_val <= w_pc1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_taken && (FLUSH_CYC != 0)) begin
                  r_state <= S_FLUSHING;
                  r_fc    <= 3'(FLUSH_CYC);
               end
            end
            S_FLUSHING: begin
               r_fc <= r_fc - 3'd1;
               if (r_fc == 3'd1) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.BR_VALID = r_br_valid;
   assign bus.TAKEN    = r_taken;
   assign bus.TARGET   = r_target;
   assign bus.LINK_WE  = r_link_we;
   assign bus.LINK_VAL = r_link_val;
   assign bus.FLUSH    = (r_state == S_FLUSHING);
   assign bus.FLAGS_Q  = r_flags;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_taken_cnt;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_br_cnt    <= '0;
         r_taken_cnt <= '0;
      end else begin
         if (w_accept && (r_br_cnt != '1)) r_br_cnt <= r_br_cnt + CNT_W'(1);
         if (w_accept && w_taken && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
   end

   assign bus.BR_CNT    = r_br_cnt;
   assign bus.TAKEN_CNT = r_taken_cnt;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table, condition sweep, flush/reset sequences.
module tb_branch_resolve_unit;
   localparam int AW = 16;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   branch_resolve_unit_if #(.ADDR_W(AW), .CNT_W(16)) u_if ();
   branch_resolve_unit #(.ADDR_W(AW), .FLUSH_CYC(2), .CNT_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .bus(u_if.slave));

`ifdef BRANCH_STATS_EN
   branch_resolve_unit_if #(.ADDR_W(AW), .CNT_W(2)) u_if2 ();
   assign u_if2.IN_VALID   = u_if.IN_VALID;
   assign u_if2.OP_TF      = u_if.OP_TF;
   assign u_if2.COND       = u_if.COND;
   assign u_if2.PC         = u_if.PC;
   assign u_if2.IMM_TARGET = u_if.IMM_TARGET;
   assign u_if2.REG_TARGET = u_if.REG_TARGET;
   assign u_if2.FLAG_WE    = u_if.FLAG_WE;
   assign u_if2.O          = u_if.O;
   assign u_if2.S          = u_if.S;
   assign u_if2.C          = u_if.C;
   assign u_if2.Z          = u_if.Z;
   branch_resolve_unit #(.ADDR_W(AW), .FLUSH_CYC(2), .CNT_W(2)) dut2 (
      .CLK(CLK), .RESET(RESET), .bus(u_if2.slave));
`endif

   typedef struct {
      logic          v;
      logic [2:0]    op;
      logic [2:0]    cond;
      logic [AW-1:0] pc;
      logic [AW-1:0] imm;
      logic [AW-1:0] rg;
      logic          fwe;
      logic [3:0]    f;
      logic          ev;
      logic          et;
      logic [AW-1:0] etg;
      logic          elw;
      logic [AW-1:0] elv;
      logic          efl;
      logic [3:0]    efq;
   } vec_t;

   vec_t tbl [13];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [2:0] op, input logic [2:0] cond,
                      input logic [AW-1:0] pc, input logic [AW-1:0] imm, input logic [AW-1:0] rg,
                      input logic fwe, input logic [3:0] f);
      u_if.IN_VALID = v;  u_if.OP_TF = op;  u_if.COND = cond;
      u_if.PC = pc;  u_if.IMM_TARGET = imm;  u_if.REG_TARGET = rg;
      u_if.FLAG_WE = fwe;
      {u_if.O, u_if.S, u_if.C, u_if.Z} = f;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      drv(1'b0, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0);
      for (int k = 0; k < n; k++) step();
   endtask

   // Reference taken decision; f is {O,S,C,Z}.
   function automatic logic ref_taken(input logic [2:0] op, input logic [2:0] cond, input logic [3:0] f);
      logic c;
      unique case (cond)
         3'b000:  c = 1'b1;
         3'b001:  c = f[2];
         3'b010:  c = f[0];
         3'b100:  c = f[1];
         3'b101:  c = f[2] && f[0];
         3'b111:  c = f[3];
         default: c = 1'b0;
      endcase
      if (op == 3'b000) return !c;
      if (op == 3'b001) return c;
      return (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
   endfunction

   initial begin
      logic [2:0] conds [6];
      logic [2:0] ops   [6];
      logic [AW-1:0] pc, etg;
      logic et;
      conds = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
      ops   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};

      //            v  op      cond    pc        imm       rg        fwe  f        ev et etg       elw elv       efl efq
      tbl[0]  = '{1'b1, 3'b001, 3'b010, 16'h0010, 16'h0200, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'h0011, 1'b0, 16'h0000, 1'b0, 4'b0000};
      tbl[1]  = '{1'b1, 3'b001, 3'b010, 16'h0010, 16'h0200, 16'h0000, 1'b1, 4'b0001, 1'b1, 1'b1, 16'h0200, 1'b0, 16'h0000, 1'b1, 4'b0001};
      tbl[2]  = '{1'b1, 3'b011, 3'b000, 16'hFFFF, 16'h0040, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0000, 1'b1, 4'b0001};
      tbl[3]  = '{1'b1, 3'b100, 3'b000, 16'h0100, 16'h0500, 16'h1234, 1'b0, 4'b0000, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 4'b0001};
      tbl[4]  = '{1'b1, 3'b000, 3'b000, 16'h0020, 16'h0222, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'h0021, 1'b0, 16'h0000, 1'b0, 4'b0001};
      tbl[5]  = '{1'b1, 3'b000, 3'b011, 16'h0030, 16'h0300, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b1, 16'h0300, 1'b0, 16'h0000, 1'b1, 4'b0001};
      tbl[6]  = '{1'b1, 3'b001, 3'b110, 16'h0040, 16'h0400, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'h0041, 1'b0, 16'h0000, 1'b0, 4'b0001};
      tbl[7]  = '{1'b1, 3'b111, 3'b000, 16'hFFFF, 16'h0700, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0001};
      tbl[8]  = '{1'b1, 3'b001, 3'b111, 16'h0005, 16'h0AAA, 16'h0000, 1'b1, 4'b1010, 1'b1, 1'b1, 16'h0AAA, 1'b0, 16'h0000, 1'b1, 4'b1010};
      tbl[9]  = '{1'b1, 3'b001, 3'b101, 16'h0007, 16'h0BBB, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'h0008, 1'b0, 16'h0000, 1'b0, 4'b1010};
      tbl[10] = '{1'b0, 3'b011, 3'b000, 16'h0123, 16'h0CCC, 16'h0000, 1'b1, 4'b0110, 1'b0, 1'b0, 16'h0008, 1'b0, 16'h0000, 1'b0, 4'b0110};
      tbl[11] = '{1'b1, 3'b011, 3'b000, 16'h0041, 16'h0099, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b1, 16'h0099, 1'b1, 16'h0042, 1'b1, 4'b0110};
      tbl[12] = '{1'b1, 3'b010, 3'b000, 16'h0050, 16'h0077, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b1, 16'h0077, 1'b0, 16'h0042, 1'b1, 4'b0110};

      // Reset with a branch presented: reset must win.
      RESET = 1'b1;
      drv(1'b1, 3'b010, 3'b000, 16'h0010, 16'h0200, 16'h0000, 1'b1, 4'b1111);
      step(); step();
      chk("rst_br_valid", u_if.BR_VALID, 0);
      chk("rst_taken",    u_if.TAKEN,    0);
      chk("rst_target",   u_if.TARGET,   0);
      chk("rst_link_we",  u_if.LINK_WE,  0);
      chk("rst_link_val", u_if.LINK_VAL, 0);
      chk("rst_flush",    u_if.FLUSH,    0);
      chk("rst_flags_q",  u_if.FLAGS_Q,  0);
      RESET = 1'b0;
      idle(1);

      for (int i = 0; i < 13; i++) begin
         drv(tbl[i].v, tbl[i].op, tbl[i].cond, tbl[i].pc, tbl[i].imm, tbl[i].rg, tbl[i].fwe, tbl[i].f);
         step();
         chk($sformatf("tbl%0d_br_valid", i), u_if.BR_VALID, tbl[i].ev);
         chk($sformatf("tbl%0d_taken", i),    u_if.TAKEN,    tbl[i].et);
         chk($sformatf("tbl%0d_target", i),   u_if.TARGET,   tbl[i].etg);
         chk($sformatf("tbl%0d_link_we", i),  u_if.LINK_WE,  tbl[i].elw);
         chk($sformatf("tbl%0d_link_val", i), u_if.LINK_VAL, tbl[i].elv);
         chk($sformatf("tbl%0d_flush", i),    u_if.FLUSH,    tbl[i].efl);
         chk($sformatf("tbl%0d_flags_q", i),  u_if.FLAGS_Q,  tbl[i].efq);
         idle(2);
      end

      // Sweep flags x cond x op using flags already latched in FLAGS_Q.
      for (int f = 0; f < 16; f++)
         for (int ci = 0; ci < 6; ci++)
            for (int oi = 0; oi < 6; oi++) begin
               drv(1'b0, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 4'(f));
               step();
               pc = 16'h1000 + 16'(f * 64 + ci * 8 + oi);
               drv(1'b1, ops[oi], conds[ci], pc, 16'h0A00, 16'h0B00, 1'b0, 4'h0);
               step();
               et  = ref_taken(ops[oi], conds[ci], 4'(f));
               etg = !et ? pc + 16'h1 : (ops[oi] == 3'b100 ? 16'h0B00 : 16'h0A00);
               chk($sformatf("sweep_f%0h_c%0d_o%0d_taken", f, conds[ci], ops[oi]), u_if.TAKEN, et);
               chk($sformatf("sweep_f%0h_c%0d_o%0d_target", f, conds[ci], ops[oi]), u_if.TARGET, etg);
               idle(2);
            end

      // Branches presented while FLUSH is high are dropped.
      drv(1'b0, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 4'b0000);
      step();
      drv(1'b1, 3'b010, 3'b000, 16'h0060, 16'h0600, 16'h0000, 1'b0, 4'h0);
      step();
      chk("drop_first_valid", u_if.BR_VALID, 1);
      chk("drop_first_flush", u_if.FLUSH, 1);
      drv(1'b1, 3'b001, 3'b000, 16'h0070, 16'h0700, 16'h0000, 1'b0, 4'h0);
      step();
      chk("drop_n2_valid", u_if.BR_VALID, 0);
      chk("drop_n2_flush", u_if.FLUSH, 1);
      step();
      chk("drop_n3_valid", u_if.BR_VALID, 0);
      chk("drop_n3_flush", u_if.FLUSH, 0);
      chk("drop_n3_target", u_if.TARGET, 16'h0600);
      step();
      chk("after_flush_valid", u_if.BR_VALID, 1);
      chk("after_flush_target", u_if.TARGET, 16'h0700);
      idle(2);

      // Back-to-back not-taken branches, one per cycle.
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 3'b001, 3'b010, 16'h0080 + 16'(k), 16'h0800, 16'h0000, 1'b0, 4'h0);
         step();
         chk($sformatf("b2b%0d_valid", k), u_if.BR_VALID, 1);
         chk($sformatf("b2b%0d_target", k), u_if.TARGET, 16'h0081 + 16'(k));
         chk($sformatf("b2b%0d_flush", k), u_if.FLUSH, 0);
      end
      idle(1);
      chk("b2b_pulse_end", u_if.BR_VALID, 0);

      // Reset during flush aborts it.
      drv(1'b1, 3'b010, 3'b000, 16'h0090, 16'h0900, 16'h0000, 1'b1, 4'b1111);
      step();
      chk("rstfl_flush_on", u_if.FLUSH, 1);
      chk("rstfl_flags_on", u_if.FLAGS_Q, 4'b1111);
      RESET = 1'b1;
      drv(1'b1, 3'b001, 3'b000, 16'h0095, 16'h0950, 16'h0000, 1'b1, 4'b1111);
      step();
      chk("rstfl_flush", u_if.FLUSH, 0);
      chk("rstfl_flags", u_if.FLAGS_Q, 0);
      chk("rstfl_valid", u_if.BR_VALID, 0);
      chk("rstfl_target", u_if.TARGET, 0);
      RESET = 1'b0;
      idle(1);
      drv(1'b1, 3'b001, 3'b010, 16'h00A0, 16'h0A0A, 16'h0000, 1'b0, 4'h0);
      step();
      chk("post_rst_valid", u_if.BR_VALID, 1);
      chk("post_rst_taken", u_if.TAKEN, 0);
      chk("post_rst_target", u_if.TARGET, 16'h00A1);
      idle(2);

`ifdef BRANCH_STATS_EN
      RESET = 1'b1;
      idle(1);
      RESET = 1'b0;
      chk("cnt_rst_br", u_if.BR_CNT, 0);
      chk("cnt_rst_taken", u_if.TAKEN_CNT, 0);
      drv(1'b1, 3'b010, 3'b000, 16'h0001, 16'h0100, 16'h0000, 1'b0, 4'h0);
      step();
      drv(1'b1, 3'b001, 3'b000, 16'h0002, 16'h0200, 16'h0000, 1'b0, 4'h0);
      step();
      idle(1);
      drv(1'b1, 3'b010, 3'b000, 16'h0003, 16'h0300, 16'h0000, 1'b0, 4'h0);
      step();
      idle(2);
      drv(1'b1, 3'b001, 3'b010, 16'h0004, 16'h0400, 16'h0000, 1'b0, 4'h0);
      step();
      drv(1'b1, 3'b001, 3'b010, 16'h0005, 16'h0500, 16'h0000, 1'b0, 4'h0);
      step();
      drv(1'b1, 3'b011, 3'b000, 16'h0006, 16'h0600, 16'h0000, 1'b0, 4'h0);
      step();
      idle(2);
      chk("cnt_br", u_if.BR_CNT, 5);
      chk("cnt_taken", u_if.TAKEN_CNT, 3);
      chk("cnt2_br_sat", u_if2.BR_CNT, 3);
      chk("cnt2_taken_sat", u_if2.TAKEN_CNT, 3);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered branch-resolution stage for the processor's execute path. Holds the architectural flag register (O, S, C, Z) and evaluates the branch condition for every branch-class instruction (jf, jt, j, jal, jr). Produces a one-cycle `BR_VALID` result carrying taken/not-taken, the next-PC target and the link write for `jal`, then holds off fetch with a parametrised flush window. It sits between decode/register-read and the PC/fetch logic, replacing the purely combinational flag tester.

## Interface
Parameters:
- `ADDR_W`, 16: PC/target width.
- `FLUSH_CYC`, 2: cycles `FLUSH` stays high after a taken branch (0 to 7; 0 = no flush).
- `CNT_W`, 16: statistics counter width (used only with `BRANCH_STATS_EN`).

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  synchronous active-high reset.
- `IN_VALID`  in  1  branch-class instruction presented this cycle.
- `OP_TF`  in  3  branch op.
- `COND`  in  3  condition select.
- `PC`  in  ADDR_W  address of the branch instruction.
- `IMM_TARGET`  in  ADDR_W  absolute target for jf/jt/j/jal.
- `REG_TARGET`  in  ADDR_W  register target for jr.
- `FLAG_WE`  in  1  ALU writes flags this cycle.
- `O`, `S`, `C`, `Z`  in  1 each  new flag values from the ALU.
- `BR_VALID`  out  1  one-cycle result strobe.
- `TAKEN`  out  1  active-high: branch redirects PC.
- `TARGET`  out  ADDR_W  next PC.
- `LINK_WE`  out  1  write `LINK_VAL` to the link register.
- `LINK_VAL`  out  ADDR_W  PC+1 for jal.
- `FLUSH`  out  1  squash fetch; new branches are ignored while high.
- `FLAGS_Q`  out  4  flag register, order {O,S,C,Z}.
- `BR_CNT`, `TAKEN_CNT`  out  CNT_W each  statistics counters (present only with `BRANCH_STATS_EN`).

## Operation
- Flag register: loads {O,S,C,Z} when `FLAG_WE` is high, independent of `FLUSH`. Reset value is 0.
- Bypass: if `FLAG_WE` and an accepted branch occur in the same cycle, the condition uses the incoming flags, not `FLAGS_Q`.
- Condition value `c`:
  - 000: 1
  - 001: S
  - 010: Z
  - 100: C
  - 101: S&Z
  - 111: O
  - 011 and 110 are reserved and give c=0.
- Taken decision by `OP_TF`:
  - 000 jf: taken = !c.
  - 001 jt: taken = c.
  - 010 j, 011 jal, 100 jr: always taken.
  - 111 and other codes: never taken.
  - jf with cond 000 is therefore never taken.
- `TARGET` selection:
  - jr taken: `REG_TARGET`.
  - Other ops, taken: `IMM_TARGET`.
  - Not taken: PC+1.
  - PC+1 wraps modulo 2^ADDR_W (PC = all-ones gives 0).
- jal: `LINK_WE`=1 and `LINK_VAL`=PC+1 (same wrap rule). For every other op, `LINK_WE`=0 and `LINK_VAL` holds its last value.
- Flush FSM:
  - States: IDLE and FLUSHING (with down-counter `fc`).
  - IDLE → FLUSHING on an accepted taken branch when `FLUSH_CYC`>0; `fc` loads `FLUSH_CYC`.
  - FLUSHING decrements `fc` each cycle and returns to IDLE when `fc` reaches 1.
  - `FLUSH` = (state == FLUSHING).
- Acceptance rule: a branch is accepted when `IN_VALID` && !`FLUSH`. `IN_VALID` during `FLUSH` is dropped: no `BR_VALID`, no counter update.

## Timing
- Accepted in cycle N: `BR_VALID`, `TAKEN`, `TARGET`, `LINK_WE` and `LINK_VAL` are registered and visible in N+1. `BR_VALID` and `LINK_WE` are single-cycle pulses.
- Taken in cycle N: `FLUSH` is high for cycles N+1 through N+FLUSH_CYC. The earliest next accepted branch is cycle N+FLUSH_CYC+1.
- Not-taken branches may be accepted back-to-back, one per cycle.
- `FLAG_WE` in cycle N updates `FLAGS_Q` in N+1.
- Reset values: `BR_VALID`=0, `TAKEN`=0, `TARGET`=0, `LINK_WE`=0, `LINK_VAL`=0, `FLUSH`=0, `FLAGS_Q`=0, counters=0, FSM=IDLE.
- `RESET` during FLUSHING aborts the flush in the next cycle.
- `RESET` has priority over all simultaneous inputs.

## Configuration
- `BRANCH_STATS_EN` defined: `BR_CNT` increments on every accepted branch, and `TAKEN_CNT` increments on every accepted taken branch. Both saturate at all-ones and clear on `RESET`.
- `BRANCH_STATS_EN` undefined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Reset, then jt cond 010 with `FLAGS_Q`=0000 → N+1: `BR_VALID`=1, `TAKEN`=0, `TARGET`=PC+1 (PC=0x0010 gives 0x0011), `FLUSH`=0.
- Same cycle: `FLAG_WE`=1 with Z=1, plus jt cond 010, `IMM_TARGET`=0x0200 → N+1: `TAKEN`=1, `TARGET`=0x0200, `FLAGS_Q`=0001. `FLUSH` is high for N+1..N+2; a jt presented in N+2 is dropped (no `BR_VALID` at N+3).
- jal with PC=0xFFFF and `IMM_TARGET`=0x0040 → `TAKEN`=1, `TARGET`=0x0040, `LINK_WE`=1, `LINK_VAL`=0x0000. jr with `REG_TARGET`=0x1234 → `TARGET`=0x1234, `LINK_WE`=0.
- Sweep all 16 flag combinations × cond {000,001,010,100,101,111} × `OP_TF` {000,001,010,011,100,111} → `TAKEN` matches the rule table. Cond 011 and 110 give c=0 (jf taken, jt not).
- Taken j followed by `RESET` in N+1 → N+2: `FLUSH`=0, `FLAGS_Q`=0, `BR_VALID`=0. A branch in N+3 is accepted.
- With `BRANCH_STATS_EN`: 5 accepted branches (3 taken) plus 1 dropped during flush → `BR_CNT`=5, `TAKEN_CNT`=3. With `CNT_W`=2, 5 accepted branches give `BR_CNT`=3 (saturated).
